// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
// Shared definitions for the interrupt controller:
//   - register offsets within the 5-word window
//   - the "no interrupt" claim ID and the hard upper limit on sources
//   - lowest_id(): fixed-priority encoder (lowest index wins) returning a 1-based ID
package irq_ctrl_pkg;

    localparam int MAX_SOURCES = 31;

    localparam logic [31:0] OFF_PENDING   = 32'h0000_0000;
    localparam logic [31:0] OFF_ENABLE    = 32'h0000_0004;
    localparam logic [31:0] OFF_TRIGGER   = 32'h0000_0008;
    localparam logic [31:0] OFF_CLAIM     = 32'h0000_000C;
    localparam logic [31:0] OFF_INSERVICE = 32'h0000_0010;

    localparam logic [4:0] ID_NONE = 5'd0;

    // Scan from the top down so the lowest set index is the last assignment.
    function automatic logic [4:0] lowest_id(input logic [MAX_SOURCES-1:0] req);
        logic [4:0] id;
        id = ID_NONE;
        for (int i = MAX_SOURCES - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 5'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge
// Two-flop synchroniser for one raw interrupt line, plus a delay flop for
// rising-edge detection.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   async_in in   raw request line (may be asynchronous to clk)
//   level    out  synchronised level (s)
//   rise     out  s & ~s_d, high for one cycle after a synchronised rising edge
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic sync_meta_reg;
    logic sync_level_reg;
    logic level_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg  <= 1'b0;
            sync_level_reg <= 1'b0;
            level_d_reg    <= 1'b0;
        end else begin
            sync_meta_reg  <= async_in;
            sync_level_reg <= sync_meta_reg;
            level_d_reg    <= sync_level_reg;
        end
    end

    assign level = sync_level_reg;
    assign rise  = sync_level_reg & ~level_d_reg;

endmodule

// File: rtl/irq_controller.sv
// irq_controller
// Memory-mapped interrupt controller: synchronises NUM_SOURCES request lines,
// latches them as pending (per-source level/edge mode), arbitrates by fixed
// priority (lowest index first) and drives one registered interrupt to the core.
// Software claims via a read of CLAIM and completes via a write of the ID.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   write_enable        bus write strobe
//   read_enable         bus read strobe (only matters for the claim side effect)
//   address             byte address, fully decoded against BASE_ADDR
//   write_data          write data
//   read_data           combinational read data, 0 for unmapped addresses
//   irq_sources         raw request lines
//   external_interrupt  registered interrupt request to the core
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_SOURCES = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_5000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write_enable,
    input  logic                   read_enable,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    input  logic [NUM_SOURCES-1:0] irq_sources,
    output logic                   external_interrupt
);

    logic [NUM_SOURCES-1:0] pending_reg,    pending_next;
    logic [NUM_SOURCES-1:0] enable_reg;
    logic [NUM_SOURCES-1:0] trigger_reg;
    logic [NUM_SOURCES-1:0] in_service_reg, in_service_next;
    logic                   ext_int_reg;

    logic [NUM_SOURCES-1:0] level_vec;
    logic [NUM_SOURCES-1:0] rise_vec;
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] claim_mask;
    logic [NUM_SOURCES-1:0] complete_mask;
    logic [NUM_SOURCES-1:0] trig_change;
    logic [MAX_SOURCES-1:0] eligible_wide;
    logic [4:0]             claim_id;

    logic hit_pending, hit_enable, hit_trigger, hit_claim, hit_inservice;
    logic claim_fire, complete_fire;

    // ---------------------------------------------------------------
    // Per-source synchronisers
    // ---------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_sync
            irq_sync_edge u_sync (
                .clk     (clk),
                .rst_n   (rst_n),
                .async_in(irq_sources[gi]),
                .level   (level_vec[gi]),
                .rise    (rise_vec[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    assign hit_pending   = (address == BASE_ADDR + OFF_PENDING);
    assign hit_enable    = (address == BASE_ADDR + OFF_ENABLE);
    assign hit_trigger   = (address == BASE_ADDR + OFF_TRIGGER);
    assign hit_claim     = (address == BASE_ADDR + OFF_CLAIM);
    assign hit_inservice = (address == BASE_ADDR + OFF_INSERVICE);

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
    assign eligible = pending_reg & enable_reg & ~in_service_reg;

    always_comb begin
        eligible_wide                  = '0;
        eligible_wide[NUM_SOURCES-1:0] = eligible;
        claim_id                       = lowest_id(eligible_wide);
    end

    // A claim read that finds nothing eligible has no side effect.
    assign claim_fire    = read_enable & hit_claim & (claim_id != ID_NONE);
    assign complete_fire = write_enable & hit_claim;

    // ---------------------------------------------------------------
    // Per-source next-state
    // ---------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            assign claim_mask[gi] = claim_fire && (claim_id == 5'(gi + 1));

            // Full 32-bit compare rejects 0, IDs above NUM_SOURCES and stray
            // upper bits; completing an ID that is not in service is a no-op.
            assign complete_mask[gi] = complete_fire
                                       && (write_data == 32'(gi + 1))
                                       && in_service_reg[gi];

            assign trig_change[gi] = write_enable && hit_trigger
                                     && (write_data[gi] != trigger_reg[gi]);

            // Edge mode: a new rise on the claim edge wins over the clear.
            // Level mode: follow the synchronised line; in-service masking
            // happens in arbitration, not here.
            assign pending_next[gi] = ~trig_change[gi] &
                (trigger_reg[gi] ? (rise_vec[gi] | (pending_reg[gi] & ~claim_mask[gi]))
                                 : level_vec[gi]);
        end
    endgenerate

    // Claim needs the source out of service and complete needs it in
    // service, so the two masks never overlap on the same bit.
    assign in_service_next = (in_service_reg & ~complete_mask) | claim_mask;

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg    <= '0;
            enable_reg     <= '0;
            trigger_reg    <= '0;
            in_service_reg <= '0;
            ext_int_reg    <= 1'b0;
        end else begin
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            ext_int_reg    <= |eligible;
            if (write_enable && hit_enable) begin
                enable_reg <= write_data[NUM_SOURCES-1:0];
            end
            if (write_enable && hit_trigger) begin
                trigger_reg <= write_data[NUM_SOURCES-1:0];
            end
        end
    end

    assign external_interrupt = ext_int_reg;

    // ---------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------
    always_comb begin
        read_data = '0;
        if (hit_pending) begin
            read_data[NUM_SOURCES-1:0] = pending_reg;
        end else if (hit_enable) begin
            read_data[NUM_SOURCES-1:0] = enable_reg;
        end else if (hit_trigger) begin
            read_data[NUM_SOURCES-1:0] = trigger_reg;
        end else if (hit_claim) begin
            read_data[4:0] = claim_id;
        end else if (hit_inservice) begin
            read_data[NUM_SOURCES-1:0] = in_service_reg;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a monitor process pops and compares on every falling clock edge.
module tb_irq_controller;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h4000_5000;
    localparam logic [31:0] O_PEND = 32'h00;
    localparam logic [31:0] O_EN   = 32'h04;
    localparam logic [31:0] O_TRIG = 32'h08;
    localparam logic [31:0] O_CLM  = 32'h0C;
    localparam logic [31:0] O_INS  = 32'h10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_enable = 1'b0;
    logic          read_enable = 1'b0;
    logic [31:0]   address = 32'h0;
    logic [31:0]   write_data = 32'h0;
    logic [31:0]   read_data;
    logic [N-1:0]  irq_sources = '0;
    logic          external_interrupt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_ext;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb_q[$];

    irq_controller #(.NUM_SOURCES(N), .BASE_ADDR(BASE)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .write_enable      (write_enable),
        .read_enable       (read_enable),
        .address           (address),
        .write_data        (write_data),
        .read_data         (read_data),
        .irq_sources       (irq_sources),
        .external_interrupt(external_interrupt)
    );

    always #5 clk = ~clk;

    // Monitor: compare everything queued during the current cycle.
    initial begin
        item_t       it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                act = it.is_ext ? {31'b0, external_interrupt} : read_data;
                n_cmp++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", it.name, act, it.exp);
                end else begin
                    $display("ok   %s: 0x%08h", it.name, act);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_ext, input logic [31:0] exp, input string name);
        item_t it;
        it.is_ext = is_ext;
        it.exp    = exp;
        it.name   = name;
        sb_q.push_back(it);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        address     = BASE + off;
        read_enable = 1'b0;
        push(1'b0, exp, name);
        tick();
        address = 32'h0;
    endtask

    task automatic claim(input logic [31:0] exp, input string name);
        address     = BASE + O_CLM;
        read_enable = 1'b1;
        push(1'b0, exp, name);
        tick();
        read_enable = 1'b0;
        address     = 32'h0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        address      = BASE + off;
        write_data   = data;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        address      = 32'h0;
        write_data   = 32'h0;
    endtask

    task automatic chk_ext(input logic exp, input string name);
        push(1'b1, {31'b0, exp}, name);
    endtask

    initial begin
        int guard;

        repeat (3) tick();
        rst_n = 1'b1;

        // ---- reset state
        chk_ext(1'b0, "reset_ext");
        rd(O_PEND, 32'h0, "reset_pending");
        rd(O_EN,   32'h0, "reset_enable");
        rd(O_TRIG, 32'h0, "reset_trigger");
        claim(32'h0, "reset_claim");
        rd(O_INS,  32'h0, "reset_inservice");

        // ---- level source 0
        wr(O_EN, 32'h1);
        wr(O_TRIG, 32'h0);
        irq_sources[0] = 1'b1;
        chk_ext(1'b0, "lvl_ext_before");
        tick(); chk_ext(1'b0, "lvl_ext_e0");
        tick(); chk_ext(1'b0, "lvl_ext_e1");
        tick(); chk_ext(1'b0, "lvl_ext_e2");
        tick(); chk_ext(1'b1, "lvl_ext_e3");
        claim(32'd1, "lvl_claim");
        chk_ext(1'b1, "lvl_ext_after_c");
        rd(O_INS, 32'h1, "lvl_inservice");
        chk_ext(1'b0, "lvl_ext_after_c1");
        claim(32'd0, "lvl_claim_masked");
        wr(O_CLM, 32'd1);
        chk_ext(1'b0, "lvl_ext_after_p");
        tick();
        chk_ext(1'b1, "lvl_ext_after_p1");
        irq_sources[0] = 1'b0;
        wr(O_EN, 32'h0);

        // ---- edge source 2
        wr(O_TRIG, 32'h4);
        wr(O_EN, 32'h4);
        irq_sources[2] = 1'b1; tick(); irq_sources[2] = 1'b0; tick(); tick();
        rd(O_PEND, 32'h4, "edge_pending");
        claim(32'd3, "edge_claim");
        rd(O_PEND, 32'h0, "edge_pending_cleared");
        rd(O_INS, 32'h4, "edge_inservice");
        irq_sources[2] = 1'b1; tick(); irq_sources[2] = 1'b0; tick(); tick();
        rd(O_PEND, 32'h4, "edge_pending_again");
        claim(32'd0, "edge_claim_in_service");
        wr(O_CLM, 32'd3);
        claim(32'd3, "edge_claim_after_complete");
        rd(O_PEND, 32'h0, "edge_pending_cleared2");
        wr(O_CLM, 32'd3);
        rd(O_INS, 32'h0, "edge_inservice_done");

        // ---- priority: sources 1 and 5 enabled, source 3 pending but disabled
        irq_sources[1] = 1'b1;
        irq_sources[3] = 1'b1;
        irq_sources[5] = 1'b1;
        wr(O_EN, 32'h22);
        tick(); tick();
        claim(32'd2, "prio_claim_first");
        claim(32'd6, "prio_claim_second");
        claim(32'd0, "prio_claim_disabled");
        rd(O_PEND, 32'h2A, "prio_pending");
        rd(O_INS, 32'h22, "prio_inservice");

        // ---- invalid completes
        wr(O_CLM, 32'd0);
        rd(O_INS, 32'h22, "inv_complete_0");
        wr(O_CLM, 32'd9);
        rd(O_INS, 32'h22, "inv_complete_9");
        wr(O_CLM, 32'd4);
        rd(O_INS, 32'h22, "inv_complete_not_serviced");
        wr(O_CLM, 32'h102);
        rd(O_INS, 32'h22, "inv_complete_upper_bits");
        wr(O_CLM, 32'd2);
        rd(O_INS, 32'h20, "valid_complete_2");
        chk_ext(1'b1, "prio_ext_after_complete");

        // ---- simultaneous edge and claim on source 4
        irq_sources[1] = 1'b0;
        irq_sources[3] = 1'b0;
        irq_sources[5] = 1'b0;
        wr(O_CLM, 32'd6);
        wr(O_EN, 32'h10);
        wr(O_TRIG, 32'h14);
        irq_sources[4] = 1'b1; tick(); irq_sources[4] = 1'b0; tick(); tick();
        rd(O_PEND, 32'h10, "sim_pending_first");
        irq_sources[4] = 1'b1; tick(); irq_sources[4] = 1'b0; tick();
        claim(32'd5, "sim_claim");
        rd(O_PEND, 32'h10, "sim_pending_kept");
        rd(O_INS, 32'h10, "sim_inservice");

        // ---- reset mid-service
        rst_n = 1'b0;
        rd(O_INS, 32'h0, "rst_inservice");
        chk_ext(1'b0, "rst_ext");
        rd(O_PEND, 32'h0, "rst_pending");
        rd(O_EN, 32'h0, "rst_enable");
        rst_n = 1'b1;
        rd(O_TRIG, 32'h0, "rst_trigger");
        claim(32'd0, "rst_claim");

        // Drain the scoreboard with a bounded wait.
        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            tick();
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d items left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller that sits directly downstream of the machine timer and other peripheral interrupt lines. It synchronises up to `NUM_SOURCES` request lines and latches them as pending, with a per-source level or edge trigger mode. It arbitrates by fixed priority and presents one registered machine external interrupt to the core. Software services an interrupt through a claim/complete register pair; the timer's `interrupt_request` is wired to source 0 in level mode.

## Interface
- `NUM_SOURCES`, 8: number of request inputs, range 1..31; source i has ID i+1, and ID 0 means "none".
- `BASE_ADDR`, 32'h40005000: base of the 5-word register window; full 32-bit address decode.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `write_enable`  in  1  bus write strobe, sampled at `clk` rising edge.
- `read_enable`  in  1  bus read strobe; used only for the claim side effect.
- `address`  in  32  byte address.
- `write_data`  in  32  write data.
- `read_data`  out  32  combinational read data; 0 for unmapped addresses.
- `irq_sources`  in  NUM_SOURCES  raw request lines, may be asynchronous.
- `external_interrupt`  out  1  registered request to the core; reset 0.

## Operation
Register map (offset from `BASE_ADDR`):
- +0x00 PENDING, read-only: `pending[N-1:0]`, upper bits 0.
- +0x04 ENABLE, RW: reset 0.
- +0x08 TRIGGER, RW: 1 = edge, 0 = level; reset 0 (all level).
- +0x0C CLAIM/COMPLETE:
  - Read returns the ID of the lowest-index source with `pending & enable & ~in_service`, or 0 if there is none.
  - A write completes a source (see Claim/complete).
- +0x10 IN_SERVICE, read-only.

Synchronisation and pending:
- Each source passes through a 2-flop synchroniser to give `s`. A third flop holds `s_d` for edge detection.
- Edge mode:
  - `pending` sets when `s & ~s_d`.
  - It clears on a claim of that source.
  - If a set and a clear for the same source land in the same cycle, the set wins.
- Level mode: `pending` is the registered value of `s`. Claims do not clear it; it is masked from arbitration while the source is in service.
- Writing TRIGGER clears `pending` for every bit whose mode changes.

Claim/complete:
- Claim condition: `read_enable` high and `address == BASE_ADDR+0x0C` at a rising edge, with a nonzero ID.
  - That edge sets `in_service[ID-1]`.
  - In edge mode it also clears `pending[ID-1]`.
  - A claim read that returns 0 has no side effect.
- A complete write of ID k clears `in_service[k-1]`.
  - A write of 0, of k > NUM_SOURCES, or of a k that is not in service is ignored.
- ENABLE does not affect `in_service`. Disabling a claimed source still needs a complete.

Output:
- `external_interrupt` is registered as `|(pending & ENABLE & ~in_service)`, computed from the current register state.

## Timing
- Reset: all pending, enable, trigger, in_service, synchroniser flops and `external_interrupt` are 0.
- Source rising edge to interrupt (source stable high before edge E0):
  - `s` = 1 after E1.
  - `pending` = 1 after E2.
  - `external_interrupt` = 1 after E3.
- Claim at edge C (no other source eligible): `in_service` is set after C, and `external_interrupt` is 0 after C+1.
- Complete at edge P for a level source still high: `external_interrupt` is 1 again after P+1.
- `read_data` is combinational from the registered state, so CLAIM returns the ID valid in the cycle of the read.
- Reset asserted mid-operation clears all state immediately; no claim survives it.

## Structure
- Package `irq_ctrl_pkg` holds:
  - register offsets (`OFF_PENDING`, `OFF_ENABLE`, `OFF_TRIGGER`, `OFF_CLAIM`, `OFF_INSERVICE`);
  - `ID_NONE = 0`;
  - the `MAX_SOURCES = 31` limit.
- One sub-module, `irq_sync_edge`: the 2-flop synchroniser plus the edge flop. It outputs `level` and `rise`, and is instantiated per source.
- Arbitration, the register file and claim/complete logic stay in `irq_controller`.

## Test plan
- Reset, then read all five offsets → every read returns 0 and `external_interrupt` = 0.
- Level source:
  1. ENABLE=0x1, TRIGGER=0, hold `irq_sources[0]`=1 → `external_interrupt` rises 3 cycles after the first sampling edge.
  2. CLAIM read → returns 1.
  3. Output → 0 one cycle after the claim.
  4. Write COMPLETE=1 with the source still high → output returns 1 one cycle later.
- Edge source:
  1. TRIGGER=0x4, ENABLE=0x4, pulse `irq_sources[2]` for 1 cycle → PENDING=0x4.
  2. CLAIM read → returns 3 and PENDING=0.
  3. A second pulse while in service → PENDING=0x4 again, and CLAIM read returns 0.
  4. COMPLETE=3 → CLAIM returns 3.
- Priority: sources 1 and 5 both pending and enabled → CLAIM returns 2; after it, the next CLAIM returns 6. Disabled pending sources are never returned.
- Simultaneous edge and claim on the same edge source in one cycle → the pending bit stays 1.
- Invalid completes:
  - COMPLETE writes of 0, of 9 (with NUM_SOURCES=8) and of a non-serviced ID → IN_SERVICE is unchanged.
  - Reset asserted mid-service → IN_SERVICE=0 and the output is 0.
